// File: rtl/bp_pkg.sv
// Shared definitions for the next-PC predictor: mode selectors, 2-bit counter
// encodings and the saturating arithmetic used on counters and perf counters.
// Pure package: no ports, no state.
package bp_pkg;

    // Prediction modes
    localparam int MODE_STATIC  = 0;   // always predict pc+4
    localparam int MODE_BIMODAL = 1;   // PHT indexed by PC bits only
    localparam int MODE_GSHARE  = 2;   // PHT indexed by PC bits XOR global history

    // 2-bit direction counter states
    localparam logic [1:0] SNT = 2'd0;  // strongly not-taken
    localparam logic [1:0] WNT = 2'd1;  // weakly not-taken
    localparam logic [1:0] WT  = 2'd2;  // weakly taken
    localparam logic [1:0] ST  = 2'd3;  // strongly taken

    function automatic logic [1:0] sat_inc(input logic [1:0] ctr);
        return (ctr == ST) ? ST : ctr + 2'd1;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] ctr);
        return (ctr == SNT) ? SNT : ctr - 2'd1;
    endfunction

    // Event counter that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] perf_inc(input logic [31:0] cnt, input logic en);
        return (en && (cnt != 32'hFFFF_FFFF)) ? cnt + 32'd1 : cnt;
    endfunction

endpackage

// File: rtl/bp_btb.sv
// Direct-mapped tagged branch target buffer: one combinational read port for
// fetch, one synchronous write port for resolved taken control flow.
// Ports: clk/reset; rd_idx/rd_tag -> rd_hit/rd_target; wr_en/wr_idx/wr_tag/wr_target.
module bp_btb
    import bp_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int IDX_BITS = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [IDX_BITS-1:0]      rd_idx,
    input  logic [XLEN-IDX_BITS-3:0] rd_tag,
    output logic                     rd_hit,
    output logic [XLEN-1:0]          rd_target,
    input  logic                     wr_en,
    input  logic [IDX_BITS-1:0]      wr_idx,
    input  logic [XLEN-IDX_BITS-3:0] wr_tag,
    input  logic [XLEN-1:0]          wr_target
);

    localparam int ENTRIES  = 1 << IDX_BITS;
    localparam int TAG_BITS = XLEN - IDX_BITS - 2;

    logic [ENTRIES-1:0] valid;
    logic [TAG_BITS-1:0] tag_mem [ENTRIES];
    logic [XLEN-1:0]     tgt_mem [ENTRIES];

    // Only the valid bits need clearing; tag/target contents are ignored
    // while an entry is invalid.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    // A write concurrent with reset is dropped so the entry stays clean.
    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            tag_mem[wr_idx] <= wr_tag;
            tgt_mem[wr_idx] <= wr_target;
        end
    end

    // No write-to-read bypass: a same-cycle write is visible next cycle.
    assign rd_hit    = valid[rd_idx] && (tag_mem[rd_idx] == rd_tag);
    assign rd_target = tgt_mem[rd_idx];

endmodule

// File: rtl/branch_predictor.sv
// Next-PC predictor beside the IF PC register: tagged BTB plus a PHT of 2-bit
// counters (static / bimodal / gshare), trained by resolved branches from EX.
// Ports: clk/reset; pc -> pred_next_pc/pred_taken/pred_ghr (zero latency);
//        upd_* resolution inputs -> mispredict (comb), perf_branches/perf_mispredicts.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int IDX_BITS = 5,
    parameter int GHR_BITS = 5,
    parameter int MODE     = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [XLEN-1:0]     pc,
    output logic [XLEN-1:0]     pred_next_pc,
    output logic                pred_taken,
    output logic [GHR_BITS-1:0] pred_ghr,
    input  logic                upd_valid,
    input  logic                upd_is_jump,
    input  logic [XLEN-1:0]     upd_pc,
    input  logic                upd_taken,
    input  logic [XLEN-1:0]     upd_target,
    input  logic                upd_pred_taken,
    input  logic [XLEN-1:0]     upd_pred_target,
    input  logic [GHR_BITS-1:0] upd_ghr,
    output logic                mispredict,
    output logic [31:0]         perf_branches,
    output logic [31:0]         perf_mispredicts
);

    localparam int ENTRIES  = 1 << IDX_BITS;
    localparam int TAG_BITS = XLEN - IDX_BITS - 2;

    logic [1:0]          pht [ENTRIES];
    logic [GHR_BITS-1:0] ghr;

    // ---------------- fetch side ----------------
    logic [IDX_BITS-1:0] fetch_bidx;
    logic [TAG_BITS-1:0] fetch_tag;
    logic [IDX_BITS-1:0] fetch_pht_idx;
    logic                btb_hit;
    logic [XLEN-1:0]     btb_target;

    assign fetch_bidx = pc[IDX_BITS+1:2];
    assign fetch_tag  = pc[XLEN-1:IDX_BITS+2];

    // History is zero-extended into the low index bits when shorter than the index.
    assign fetch_pht_idx = (MODE == MODE_GSHARE) ? (fetch_bidx ^ IDX_BITS'(ghr)) : fetch_bidx;

    // Static mode never predicts taken even though the tables keep training.
    // Outputs are held at their reset values while reset is asserted.
    assign pred_taken   = !reset && (MODE != MODE_STATIC) && btb_hit && pht[fetch_pht_idx][1];
    assign pred_next_pc = pred_taken ? btb_target : pc + XLEN'(4);
    assign pred_ghr     = ghr;

    // ---------------- resolve side ----------------
    logic [IDX_BITS-1:0] upd_bidx;
    logic [TAG_BITS-1:0] upd_tag;
    logic [IDX_BITS-1:0] upd_pht_idx;
    logic [XLEN-1:0]     actual_next_pc;
    logic                btb_wr;

    assign upd_bidx = upd_pc[IDX_BITS+1:2];
    assign upd_tag  = upd_pc[XLEN-1:IDX_BITS+2];

    // Train the counter that was actually consulted: use the carried history,
    // not the live GHR, which may have moved on since that fetch.
    assign upd_pht_idx = (MODE == MODE_GSHARE) ? (upd_bidx ^ IDX_BITS'(upd_ghr)) : upd_bidx;

    assign actual_next_pc = upd_taken ? upd_target : upd_pc + XLEN'(4);
    assign mispredict     = !reset && upd_valid && (actual_next_pc != upd_pred_target);

    // Not-taken branches leave the BTB alone so a taken alias is not evicted.
    assign btb_wr = upd_valid && upd_taken;

    // The predicted direction is implied by upd_pred_target, which is all the
    // mispredict decision needs.
    logic unused_pred_dir;
    assign unused_pred_dir = upd_pred_taken;

    bp_btb #(
        .XLEN     (XLEN),
        .IDX_BITS (IDX_BITS)
    ) u_btb (
        .clk       (clk),
        .reset     (reset),
        .rd_idx    (fetch_bidx),
        .rd_tag    (fetch_tag),
        .rd_hit    (btb_hit),
        .rd_target (btb_target),
        .wr_en     (btb_wr),
        .wr_idx    (upd_bidx),
        .wr_tag    (upd_tag),
        .wr_target (upd_target)
    );

    // Counters reset to weakly not-taken so one taken resolution flips them.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                pht[i] <= WNT;
            end
        end else if (upd_valid) begin
            if (upd_is_jump) begin
                pht[upd_pht_idx] <= ST;
            end else if (upd_taken) begin
                pht[upd_pht_idx] <= sat_inc(pht[upd_pht_idx]);
            end else begin
                pht[upd_pht_idx] <= sat_dec(pht[upd_pht_idx]);
            end
        end
    end

    // Only conditional branches shift history; jumps carry no direction info.
    always_ff @(posedge clk) begin
        if (reset) begin
            ghr <= '0;
        end else if (upd_valid && !upd_is_jump) begin
            ghr <= {ghr[GHR_BITS-2:0], upd_taken};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_branches    <= '0;
            perf_mispredicts <= '0;
        end else begin
            perf_branches    <= perf_inc(perf_branches, upd_valid);
            perf_mispredicts <= perf_inc(perf_mispredicts, mispredict);
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        upd_valid, upd_is_jump, upd_taken, upd_pred_taken;
    logic [31:0] upd_pc, upd_target, upd_pred_target;
    logic [4:0]  upd_ghr;

    logic [31:0] o_next [3];
    logic        o_taken [3];
    logic [4:0]  o_ghr [3];
    logic        o_mp [3];
    logic [31:0] o_pbr [3];
    logic [31:0] o_pmp [3];

    always #5 clk = ~clk;

    // One instance per mode, all driven by the same stimulus.
    for (genvar m = 0; m < 3; m++) begin : g_dut
        branch_predictor #(
            .XLEN(32), .IDX_BITS(5), .GHR_BITS(5), .MODE(m)
        ) u_dut (
            .clk              (clk),
            .reset            (reset),
            .pc               (pc),
            .pred_next_pc     (o_next[m]),
            .pred_taken       (o_taken[m]),
            .pred_ghr         (o_ghr[m]),
            .upd_valid        (upd_valid),
            .upd_is_jump      (upd_is_jump),
            .upd_pc           (upd_pc),
            .upd_taken        (upd_taken),
            .upd_target       (upd_target),
            .upd_pred_taken   (upd_pred_taken),
            .upd_pred_target  (upd_pred_target),
            .upd_ghr          (upd_ghr),
            .mispredict       (o_mp[m]),
            .perf_branches    (o_pbr[m]),
            .perf_mispredicts (o_pmp[m])
        );
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_valid [32];
    logic [31:0] m_tag [32];
    logic [31:0] m_tgt [32];
    int          m_pht [3][32];
    int          m_ghr;
    int          m_br;
    int          m_mp;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_valid[i] = 1'b0;
            for (int m = 0; m < 3; m++) m_pht[m][i] = 1;
        end
        m_ghr = 0;
        m_br  = 0;
        m_mp  = 0;
    endtask

    function automatic int m_bidx(input logic [31:0] p);
        return int'((p >> 2) % 32);
    endfunction

    function automatic int m_idx(input int m, input logic [31:0] p, input int g);
        return (m == 2) ? (m_bidx(p) ^ g) : m_bidx(p);
    endfunction

    function automatic bit m_pred_taken(input int m, input logic [31:0] p);
        int b = m_bidx(p);
        bit hit = m_valid[b] && (m_tag[b] == (p >> 7));
        return (m != 0) && hit && (m_pht[m][m_idx(m, p, m_ghr)] >= 2);
    endfunction

    function automatic logic [31:0] m_pred_next(input int m, input logic [31:0] p);
        return m_pred_taken(m, p) ? m_tgt[m_bidx(p)] : p + 32'd4;
    endfunction

    function automatic bit m_mispredict();
        logic [31:0] actual = upd_taken ? upd_target : upd_pc + 32'd4;
        return !reset && upd_valid && (actual != upd_pred_target);
    endfunction

    task automatic model_update();
        int b = m_bidx(upd_pc);
        m_br++;
        if (m_mispredict()) m_mp++;
        for (int m = 0; m < 3; m++) begin
            int ix = m_idx(m, upd_pc, int'(upd_ghr));
            if (upd_is_jump)    m_pht[m][ix] = 3;
            else if (upd_taken) m_pht[m][ix] = (m_pht[m][ix] == 3) ? 3 : m_pht[m][ix] + 1;
            else                m_pht[m][ix] = (m_pht[m][ix] == 0) ? 0 : m_pht[m][ix] - 1;
        end
        if (!upd_is_jump) m_ghr = ((m_ghr * 2) + int'(upd_taken)) % 32;
        if (upd_taken) begin
            m_valid[b] = 1'b1;
            m_tag[b]   = upd_pc >> 7;
            m_tgt[b]   = upd_target;
        end
    endtask

    task automatic check_model();
        for (int m = 0; m < 3; m++) begin
            chk($sformatf("m%0d_pred_taken pc=%08h", m, pc), 32'(o_taken[m]),
                reset ? 32'd0 : 32'(m_pred_taken(m, pc)));
            chk($sformatf("m%0d_pred_next_pc pc=%08h", m, pc), o_next[m],
                reset ? pc + 32'd4 : m_pred_next(m, pc));
            chk($sformatf("m%0d_pred_ghr", m), 32'(o_ghr[m]), 32'(m_ghr));
            chk($sformatf("m%0d_mispredict", m), 32'(o_mp[m]), 32'(m_mispredict()));
            chk($sformatf("m%0d_perf_branches", m), o_pbr[m], 32'(m_br));
            chk($sformatf("m%0d_perf_mispredicts", m), o_pmp[m], 32'(m_mp));
        end
    endtask

    task automatic commit_model();
        if (reset) model_reset();
        else if (upd_valid) model_update();
    endtask

    // Inputs are driven just after posedge; outputs sampled at negedge.
    task automatic step();
        @(negedge clk);
        check_model();
        commit_model();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_pc();
        return (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 31)) << 2);
    endfunction

    task automatic idle_upd();
        upd_valid = 1'b0; upd_is_jump = 1'b0; upd_pc = '0; upd_taken = 1'b0;
        upd_target = '0; upd_pred_target = '0; upd_pred_taken = 1'b0; upd_ghr = '0;
    endtask

    // ---------------- directed table (bimodal instance) ----------------
    typedef struct {
        logic [31:0] pc;
        logic        uv;
        logic        uj;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utgt;
        logic [31:0] uptgt;
        logic        exp_taken;
        logic [31:0] exp_next;
        logic        exp_mp;
        logic [4:0]  exp_ghr;
        int          exp_br;
        int          exp_mpc;
    } vec_t;

    vec_t tbl [14];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int mp_base;
        tbl[0]  = '{32'h100, 0, 0, 32'h0,  0, 32'h0,   32'h0,   0, 32'h104, 0, 5'd0,  0, 0};
        tbl[1]  = '{32'h040, 1, 0, 32'h40, 1, 32'h80,  32'h44,  0, 32'h044, 1, 5'd0,  0, 0};
        tbl[2]  = '{32'h040, 0, 0, 32'h0,  0, 32'h0,   32'h0,   1, 32'h080, 0, 5'd1,  1, 1};
        tbl[3]  = '{32'h040, 1, 0, 32'h40, 0, 32'h80,  32'h80,  1, 32'h080, 1, 5'd1,  1, 1};
        tbl[4]  = '{32'h040, 1, 0, 32'h40, 0, 32'h80,  32'h44,  0, 32'h044, 0, 5'd2,  2, 2};
        tbl[5]  = '{32'h040, 0, 0, 32'h0,  0, 32'h0,   32'h0,   0, 32'h044, 0, 5'd4,  3, 2};
        tbl[6]  = '{32'h040, 1, 0, 32'h40, 1, 32'h80,  32'h44,  0, 32'h044, 1, 5'd4,  3, 2};
        tbl[7]  = '{32'h040, 1, 0, 32'h40, 1, 32'h80,  32'h44,  0, 32'h044, 1, 5'd9,  4, 3};
        tbl[8]  = '{32'h040, 0, 0, 32'h0,  0, 32'h0,   32'h0,   1, 32'h080, 0, 5'd19, 5, 4};
        tbl[9]  = '{32'h0C0, 1, 0, 32'hC0, 1, 32'h300, 32'hC4,  0, 32'h0C4, 1, 5'd19, 5, 4};
        tbl[10] = '{32'h040, 0, 0, 32'h0,  0, 32'h0,   32'h0,   0, 32'h044, 0, 5'd7,  6, 5};
        tbl[11] = '{32'h0C0, 0, 0, 32'h0,  0, 32'h0,   32'h0,   1, 32'h300, 0, 5'd7,  6, 5};
        tbl[12] = '{32'h020, 1, 1, 32'h20, 1, 32'h200, 32'h24,  0, 32'h024, 1, 5'd7,  6, 5};
        tbl[13] = '{32'h020, 0, 0, 32'h0,  0, 32'h0,   32'h0,   1, 32'h200, 0, 5'd7,  7, 6};

        reset = 1'b1;
        pc = 32'h100;
        idle_upd();
        model_reset();
        @(posedge clk);
        #1;
        step();
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            pc              = tbl[i].pc;
            upd_valid       = tbl[i].uv;
            upd_is_jump     = tbl[i].uj;
            upd_pc          = tbl[i].upc;
            upd_taken       = tbl[i].ut;
            upd_target      = tbl[i].utgt;
            upd_pred_target = tbl[i].uptgt;
            upd_pred_taken  = (tbl[i].uptgt != tbl[i].upc + 32'd4);
            upd_ghr         = 5'(m_ghr);
            @(negedge clk);
            chk($sformatf("tbl%0d_pred_taken", i), 32'(o_taken[1]), 32'(tbl[i].exp_taken));
            chk($sformatf("tbl%0d_pred_next_pc", i), o_next[1], tbl[i].exp_next);
            chk($sformatf("tbl%0d_mispredict", i), 32'(o_mp[1]), 32'(tbl[i].exp_mp));
            chk($sformatf("tbl%0d_ghr", i), 32'(o_ghr[1]), 32'(tbl[i].exp_ghr));
            chk($sformatf("tbl%0d_perf_br", i), o_pbr[1], 32'(tbl[i].exp_br));
            chk($sformatf("tbl%0d_perf_mp", i), o_pmp[1], 32'(tbl[i].exp_mpc));
            chk($sformatf("tbl%0d_static_next", i), o_next[0], tbl[i].pc + 32'd4);
            check_model();
            commit_model();
            @(posedge clk);
            #1;
        end

        // Reset coinciding with an update: the write is dropped, tables cleared.
        reset = 1'b1;
        pc = 32'h20;
        upd_valid = 1'b1; upd_is_jump = 1'b0; upd_pc = 32'h60; upd_taken = 1'b1;
        upd_target = 32'h400; upd_pred_target = 32'h64; upd_ghr = 5'(m_ghr);
        step();
        reset = 1'b0;
        idle_upd();
        pc = 32'h60;
        @(negedge clk);
        chk("rst_upd_dropped_next", o_next[1], 32'h64);
        chk("rst_upd_dropped_taken", 32'(o_taken[2]), 32'd0);
        chk("rst_ghr_cleared", 32'(o_ghr[2]), 32'd0);
        chk("rst_perf_br_cleared", o_pbr[1], 32'd0);
        chk("rst_perf_mp_cleared", o_pmp[1], 32'd0);
        @(posedge clk);
        #1;
        pc = 32'h20;
        @(negedge clk);
        chk("rst_jump_entry_cleared", o_next[1], 32'h24);
        @(posedge clk);
        #1;

        // gshare on an alternating branch: once history is warm, no mispredicts.
        mp_base = 0;
        for (int k = 0; k < 32; k++) begin
            pc              = 32'h40;
            upd_valid       = 1'b1;
            upd_is_jump     = 1'b0;
            upd_pc          = 32'h40;
            upd_taken       = (k % 2 == 0);
            upd_target      = 32'h80;
            upd_pred_target = m_pred_next(2, 32'h40);
            upd_pred_taken  = m_pred_taken(2, 32'h40);
            upd_ghr         = 5'(m_ghr);
            if (k == 12) mp_base = m_mp;
            @(negedge clk);
            if (k >= 12) chk($sformatf("gshare_alt_mispredict k=%0d", k), 32'(o_mp[2]), 32'd0);
            check_model();
            commit_model();
            @(posedge clk);
            #1;
        end
        idle_upd();
        @(negedge clk);
        chk("gshare_alt_perf_mp_flat", o_pmp[2], 32'(mp_base));
        @(posedge clk);
        #1;

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            reset       = ($urandom_range(0, 99) == 0);
            pc          = rand_pc();
            upd_valid   = ($urandom_range(0, 99) < 70);
            upd_is_jump = ($urandom_range(0, 4) == 0);
            upd_pc      = rand_pc();
            upd_taken   = upd_is_jump ? 1'b1 : 1'($urandom_range(0, 1));
            upd_target  = $urandom & 32'hFFFF_FFFC;
            case ($urandom_range(0, 3))
                0, 1:    upd_pred_target = m_pred_next(2, upd_pc);
                2:       upd_pred_target = upd_pc + 32'd4;
                default: upd_pred_target = upd_target;
            endcase
            upd_pred_taken = (upd_pred_target != upd_pc + 32'd4);
            upd_ghr = ($urandom_range(0, 1) == 0) ? 5'(m_ghr) : 5'($urandom_range(0, 31));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
